// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - game-stage state types and round defaults
package game_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    NEXT     = 2'd2,
    FINISHED = 2'd3
  } shot_state_t;

  localparam int SHOTS_PER_DUCK = 3;
  localparam int DUCKS_PER_GAME = 10;
endpackage

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - display geometry shared by game-stage blocks
package vga_pkg;
  localparam int DUCK_WIDTH  = 64;
  localparam int DUCK_HEIGHT = 64;
endpackage

// File: rtl/bcd_counter_3d.sv
// rtl/bcd_counter_3d.sv - three-digit BCD incrementer, sync clear, saturates at 999
module bcd_counter_3d (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [11:0] value_o
);
  logic [11:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = 12'h000;
    end else if (en_i && value_q != 12'h999) begin
      if (value_q[3:0] != 4'd9) begin
        value_d[3:0] = value_q[3:0] + 4'd1;
      end else begin
        value_d[3:0] = 4'd0;
        if (value_q[7:4] != 4'd9) begin
          value_d[7:4] = value_q[7:4] + 4'd1;
        end else begin
          value_d[7:4]  = 4'd0;
          value_d[11:8] = value_q[11:8] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) value_q <= 12'h000;
    else       value_q <= value_d;
  end

  assign value_o = value_q;
endmodule

// File: rtl/shot_ctl.sv
// rtl/shot_ctl.sv - turns clicks into shots, scores hits, tracks budget and timeout
module shot_ctl
  import game_pkg::*;
#(
  parameter int          DUCK_WIDTH     = vga_pkg::DUCK_WIDTH,
  parameter int          DUCK_HEIGHT    = vga_pkg::DUCK_HEIGHT,
  parameter int          SHOTS_PER_DUCK = game_pkg::SHOTS_PER_DUCK,
  parameter int          DUCKS_PER_GAME = game_pkg::DUCKS_PER_GAME,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd325_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_enable,
  input  logic        left_mouse,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic [11:0] duck_xpos,
  input  logic [11:0] duck_ypos,
  output logic        duck_hit,
  output logic        duck_escaped,
  output logic [1:0]  shots_left,
  output logic [3:0]  ducks_done,
  output logic [11:0] score,
  output logic        game_finished
);
  shot_state_t state_q;
  logic        left_mouse_q, left_mouse_qq;
  logic        duck_hit_q, duck_escaped_q, game_finished_q;
  logic [1:0]  shots_q;
  logic [3:0]  ducks_q;
  logic [31:0] timer_q;

  logic click, hit, timeout, score_inc, score_clr;
  logic [12:0] mx, my, dx, dy;

  // The button is registered once before edge detection, so a press sampled
  // at edge k is acted on at edge k+1 with positions current at that edge.
  assign click   = left_mouse_q & ~left_mouse_qq;
  assign mx      = {1'b0, mouse_xpos};
  assign my      = {1'b0, mouse_ypos};
  assign dx      = {1'b0, duck_xpos};
  assign dy      = {1'b0, duck_ypos};
  assign hit     = (dx <= mx) && (mx < dx + 13'(DUCK_WIDTH)) &&
                   (dy <= my) && (my < dy + 13'(DUCK_HEIGHT));
  assign timeout = (timer_q == TIMEOUT_CYCLES - 32'd1);

  assign score_inc = game_enable && (state_q == ARMED) && click && hit;
  assign score_clr = game_enable && (state_q == IDLE);

  bcd_counter_3d u_score (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (score_clr),
    .en_i    (score_inc),
    .value_o (score)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      left_mouse_q    <= 1'b0;
      left_mouse_qq   <= 1'b0;
      duck_hit_q      <= 1'b0;
      duck_escaped_q  <= 1'b0;
      game_finished_q <= 1'b0;
      shots_q         <= 2'd0;
      ducks_q         <= 4'd0;
      timer_q         <= 32'd0;
    end else begin
      left_mouse_q   <= left_mouse;
      left_mouse_qq  <= left_mouse_q;
      duck_hit_q     <= 1'b0;
      duck_escaped_q <= 1'b0;
      if (!game_enable) begin
        state_q         <= IDLE;
        game_finished_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            ducks_q         <= 4'd0;
            timer_q         <= 32'd0;
            shots_q         <= 2'(SHOTS_PER_DUCK);
            game_finished_q <= 1'b0;
            state_q         <= ARMED;
          end
          ARMED: begin
            timer_q <= timer_q + 32'd1;
            if (click) begin
              shots_q <= shots_q - 2'd1;
              if (hit) begin
                duck_hit_q <= 1'b1;
                state_q    <= NEXT;
              end else if (shots_q == 2'd1 || timeout) begin
                duck_escaped_q <= 1'b1;
                state_q        <= NEXT;
              end
            end else if (timeout) begin
              duck_escaped_q <= 1'b1;
              state_q        <= NEXT;
            end
          end
          NEXT: begin
            ducks_q <= ducks_q + 4'd1;
            if (ducks_q + 4'd1 == 4'(DUCKS_PER_GAME)) begin
              game_finished_q <= 1'b1;
              state_q         <= FINISHED;
            end else begin
              shots_q <= 2'(SHOTS_PER_DUCK);
              timer_q <= 32'd0;
              state_q <= ARMED;
            end
          end
          default: begin
            game_finished_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign duck_hit      = duck_hit_q;
  assign duck_escaped  = duck_escaped_q;
  assign shots_left    = shots_q;
  assign ducks_done    = ducks_q;
  assign game_finished = game_finished_q;
endmodule

// File: tb/tb_shot_ctl.sv
// tb/tb_shot_ctl.sv - directed self-checking bench for shot_ctl
module tb_shot_ctl;
  logic clk = 1'b0;
  logic rst;
  logic game_enable_a, game_enable_b, left_mouse;
  logic [11:0] mouse_x, mouse_y, duck_x, duck_y;

  logic hit_a, esc_a, gf_a;
  logic [1:0] shots_a;
  logic [3:0] ducks_a;
  logic [11:0] score_a;

  logic hit_b, esc_b, gf_b;
  logic [1:0] shots_b;
  logic [3:0] ducks_b;
  logic [11:0] score_b;

  logic bcd_clr, bcd_en;
  logic [11:0] bcd_val;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  shot_ctl #(.TIMEOUT_CYCLES(32'd1000)) dut_a (
    .clk(clk), .rst(rst), .game_enable(game_enable_a), .left_mouse(left_mouse),
    .mouse_xpos(mouse_x), .mouse_ypos(mouse_y), .duck_xpos(duck_x), .duck_ypos(duck_y),
    .duck_hit(hit_a), .duck_escaped(esc_a), .shots_left(shots_a),
    .ducks_done(ducks_a), .score(score_a), .game_finished(gf_a)
  );

  shot_ctl #(.TIMEOUT_CYCLES(32'd20)) dut_b (
    .clk(clk), .rst(rst), .game_enable(game_enable_b), .left_mouse(left_mouse),
    .mouse_xpos(mouse_x), .mouse_ypos(mouse_y), .duck_xpos(duck_x), .duck_ypos(duck_y),
    .duck_hit(hit_b), .duck_escaped(esc_b), .shots_left(shots_b),
    .ducks_done(ducks_b), .score(score_b), .game_finished(gf_b)
  );

  bcd_counter_3d u_bcd (
    .clk_i(clk), .rst_i(rst), .clr_i(bcd_clr), .en_i(bcd_en), .value_o(bcd_val)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic press(input logic [11:0] x, input logic [11:0] y);
    mouse_x = x;
    mouse_y = y;
    left_mouse = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic release_btn();
    left_mouse = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    if ({hit_a, esc_a, gf_a, shots_a, ducks_a, score_a} !== 21'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %0h want 0", {hit_a, esc_a, gf_a, shots_a, ducks_a, score_a});
    end
    tests_run++;
  endtask

  task automatic test_start();
    game_enable_a = 1'b1;
    @(negedge clk);
    if (shots_a !== 2'd3) begin tests_failed++; $display("FAIL start_shots: got %0d want 3", shots_a); end
    tests_run++;
    if (score_a !== 12'h000) begin tests_failed++; $display("FAIL start_score: got %0h want 000", score_a); end
    tests_run++;
  endtask

  task automatic test_hit();
    press(12'd130, 12'd150);
    if ({hit_a, esc_a} !== 2'b10) begin tests_failed++; $display("FAIL hit_pulse: got %b want 10", {hit_a, esc_a}); end
    tests_run++;
    if (score_a !== 12'h001) begin tests_failed++; $display("FAIL hit_score: got %0h want 001", score_a); end
    tests_run++;
    if (shots_a !== 2'd2) begin tests_failed++; $display("FAIL hit_shots: got %0d want 2", shots_a); end
    tests_run++;
    release_btn();
    if (hit_a !== 1'b0) begin tests_failed++; $display("FAIL hit_one_cycle: got %b want 0", hit_a); end
    tests_run++;
    if (shots_a !== 2'd3) begin tests_failed++; $display("FAIL hit_reload: got %0d want 3", shots_a); end
    tests_run++;
    if (ducks_a !== 4'd1) begin tests_failed++; $display("FAIL hit_ducks: got %0d want 1", ducks_a); end
    tests_run++;
  endtask

  task automatic test_edges();
    press(12'd164, 12'd100);
    if ({hit_a, esc_a} !== 2'b00) begin tests_failed++; $display("FAIL right_edge_pulse: got %b want 00", {hit_a, esc_a}); end
    tests_run++;
    if (shots_a !== 2'd2) begin tests_failed++; $display("FAIL right_edge_shots: got %0d want 2", shots_a); end
    tests_run++;
    release_btn();
    press(12'd163, 12'd163);
    if (hit_a !== 1'b1) begin tests_failed++; $display("FAIL last_pixel_hit: got %b want 1", hit_a); end
    tests_run++;
    release_btn();
    if (score_a !== 12'h002 || ducks_a !== 4'd2) begin
      tests_failed++;
      $display("FAIL last_pixel_state: got score %0h ducks %0d want 002 2", score_a, ducks_a);
    end
    tests_run++;
  endtask

  task automatic test_three_misses();
    logic [1:0] want_shots;
    for (int i = 0; i < 3; i++) begin
      press(12'd0, 12'd0);
      want_shots = 2'(2 - i);
      if (shots_a !== want_shots) begin tests_failed++; $display("FAIL miss_shots_%0d: got %0d want %0d", i, shots_a, want_shots); end
      tests_run++;
      if (esc_a !== (i == 2)) begin tests_failed++; $display("FAIL miss_escape_%0d: got %b want %b", i, esc_a, (i == 2)); end
      tests_run++;
      release_btn();
    end
    if (ducks_a !== 4'd3 || score_a !== 12'h002) begin
      tests_failed++;
      $display("FAIL miss_totals: got ducks %0d score %0h want 3 002", ducks_a, score_a);
    end
    tests_run++;
  endtask

  task automatic test_hold();
    int pulses = 0;
    mouse_x = 12'd0;
    mouse_y = 12'd0;
    left_mouse = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hit_a || esc_a) pulses++;
    end
    if (shots_a !== 2'd2) begin tests_failed++; $display("FAIL hold_shots: got %0d want 2", shots_a); end
    tests_run++;
    if (pulses != 0) begin tests_failed++; $display("FAIL hold_pulses: got %0d want 0", pulses); end
    tests_run++;
    release_btn();
  endtask

  task automatic test_enable_drop();
    int pulses = 0;
    game_enable_a = 1'b0;
    mouse_x = 12'd120;
    mouse_y = 12'd120;
    left_mouse = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (hit_a || esc_a) pulses++;
    end
    if (pulses != 0) begin tests_failed++; $display("FAIL drop_pulses: got %0d want 0", pulses); end
    tests_run++;
    if (score_a !== 12'h002 || ducks_a !== 4'd3) begin
      tests_failed++;
      $display("FAIL drop_retain: got score %0h ducks %0d want 002 3", score_a, ducks_a);
    end
    tests_run++;
    release_btn();
    game_enable_a = 1'b1;
    @(negedge clk);
    if (score_a !== 12'h000 || ducks_a !== 4'd0 || shots_a !== 2'd3) begin
      tests_failed++;
      $display("FAIL restart_clear: got score %0h ducks %0d shots %0d want 000 0 3", score_a, ducks_a, shots_a);
    end
    tests_run++;
  endtask

  task automatic test_finish();
    logic [11:0] want_score;
    for (int i = 0; i < 10; i++) begin
      press(12'd120, 12'd120);
      want_score = (i == 9) ? 12'h010 : 12'(i + 1);
      if (hit_a !== 1'b1 || score_a !== want_score) begin
        tests_failed++;
        $display("FAIL game_hit_%0d: got hit %b score %0h want 1 %0h", i, hit_a, score_a, want_score);
      end
      tests_run++;
      release_btn();
      if (gf_a !== (i == 9)) begin tests_failed++; $display("FAIL game_finished_%0d: got %b want %b", i, gf_a, (i == 9)); end
      tests_run++;
    end
    if (ducks_a !== 4'd10) begin tests_failed++; $display("FAIL final_ducks: got %0d want 10", ducks_a); end
    tests_run++;
    press(12'd120, 12'd120);
    release_btn();
    if (score_a !== 12'h010 || ducks_a !== 4'd10 || gf_a !== 1'b1 || hit_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL finished_ignores: got score %0h ducks %0d gf %b hit %b want 010 10 1 0", score_a, ducks_a, gf_a, hit_a);
    end
    tests_run++;
    game_enable_a = 1'b0;
    @(negedge clk);
    if (gf_a !== 1'b0 || score_a !== 12'h010 || ducks_a !== 4'd10) begin
      tests_failed++;
      $display("FAIL end_screen: got gf %b score %0h ducks %0d want 0 010 10", gf_a, score_a, ducks_a);
    end
    tests_run++;
  endtask

  task automatic test_timeout();
    int first_esc = -1;
    int esc_count = 0;
    logic hit_seen = 1'b0;
    mouse_x = 12'd110;
    mouse_y = 12'd110;
    game_enable_b = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (esc_b) begin
        esc_count++;
        if (first_esc < 0) first_esc = i;
      end
      if (i == 41) hit_seen = hit_b;
      if (i == 39) left_mouse = 1'b1;
      if (i == 42) left_mouse = 1'b0;
    end
    if (first_esc != 20) begin tests_failed++; $display("FAIL timeout_cycle: got %0d want 20", first_esc); end
    tests_run++;
    if (esc_count != 1) begin tests_failed++; $display("FAIL timeout_esc_count: got %0d want 1", esc_count); end
    tests_run++;
    if (hit_seen !== 1'b1 || score_b !== 12'h001) begin
      tests_failed++;
      $display("FAIL timeout_click_hit: got hit %b score %0h want 1 001", hit_seen, score_b);
    end
    tests_run++;
    if (ducks_b !== 4'd2) begin tests_failed++; $display("FAIL timeout_ducks: got %0d want 2", ducks_b); end
    tests_run++;
  endtask

  task automatic test_saturate();
    bcd_clr = 1'b1;
    @(negedge clk);
    bcd_clr = 1'b0;
    bcd_en = 1'b1;
    repeat (10) @(negedge clk);
    if (bcd_val !== 12'h010) begin tests_failed++; $display("FAIL bcd_carry: got %0h want 010", bcd_val); end
    tests_run++;
    repeat (989) @(negedge clk);
    if (bcd_val !== 12'h999) begin tests_failed++; $display("FAIL bcd_999: got %0h want 999", bcd_val); end
    tests_run++;
    repeat (5) @(negedge clk);
    if (bcd_val !== 12'h999) begin tests_failed++; $display("FAIL bcd_saturate: got %0h want 999", bcd_val); end
    tests_run++;
    bcd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    game_enable_a = 1'b0;
    game_enable_b = 1'b0;
    left_mouse = 1'b0;
    mouse_x = 12'd0;
    mouse_y = 12'd0;
    duck_x = 12'd100;
    duck_y = 12'd100;
    bcd_clr = 1'b0;
    bcd_en = 1'b0;
    @(negedge clk);
    test_reset();
    test_start();
    test_hit();
    test_edges();
    test_three_misses();
    test_hold();
    test_enable_drop();
    test_finish();
    test_timeout();
    test_saturate();
    chk("bench_tail_score_a", {20'd0, score_a}, 32'h010);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
